// File: rtl/hamming74_decoder.sv
// Hamming(7,4) decoder: syndrome stage, correction stage,
// saturating correction counter and fixed-length frame close.
module hamming74_decoder #(
    parameter int MAX_WORDS = 7,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:6]       byte_in,
    input  logic             active,
    output logic [0:3]       bits_out,
    output logic             ready,
    output logic [2:0]       err_pos,
    output logic [CNT_W-1:0] err_cnt,
    output logic             done
);

    localparam int WC_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [WC_W-1:0] word_cnt;
    logic            v1;
    logic [0:6]      s1_code;
    logic [2:0]      s1_syn;

    logic [2:0]      syn_in;
    logic            accept;
    logic            last_word;
    logic [2:0]      pos;
    logic [0:3]      fixed;

    // Syndrome packed as {s4,s5,s6}
    function automatic logic [2:0] syndrome(input logic [0:6] c);
        syndrome = {c[4] ^ c[0] ^ c[1] ^ c[3],
                    c[5] ^ c[0] ^ c[2] ^ c[3],
                    c[6] ^ c[1] ^ c[2] ^ c[3]};
    endfunction

    always_comb begin
        syn_in    = syndrome(byte_in);
        accept    = active && (state != DONE);
        last_word = (word_cnt == WC_W'(MAX_WORDS - 1));
    end

    always_comb begin
        pos = 3'd0;
        unique case (s1_syn)
            3'b110:  pos = 3'd1;
            3'b101:  pos = 3'd2;
            3'b011:  pos = 3'd3;
            3'b111:  pos = 3'd4;
            3'b100:  pos = 3'd5;
            3'b010:  pos = 3'd6;
            3'b001:  pos = 3'd7;
            default: pos = 3'd0;
        endcase
    end

    // Parity-bit errors (pos 5..7) leave the data untouched
    always_comb begin
        fixed = s1_code[0:3];
        unique case (pos)
            3'd1:    fixed[0] = ~s1_code[0];
            3'd2:    fixed[1] = ~s1_code[1];
            3'd3:    fixed[2] = ~s1_code[2];
            3'd4:    fixed[3] = ~s1_code[3];
            default: fixed = s1_code[0:3];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            v1       <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            bits_out <= '0;
            ready    <= 1'b0;
            err_pos  <= '0;
            err_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            ready <= 1'b0;
            v1    <= accept;
            if (accept) begin
                s1_code  <= byte_in;
                s1_syn   <= syn_in;
                word_cnt <= word_cnt + WC_W'(1);
                if (last_word) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end
            if (v1) begin
                bits_out <= fixed;
                err_pos  <= pos;
                ready    <= 1'b1;
                if ((s1_syn != 3'd0) && (err_cnt != {CNT_W{1'b1}}))
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming74_decoder.sv
// Bench for hamming74_decoder: nearest-codeword reference model,
// two instances (8-bit and 2-bit correction counters).
module tb_hamming74_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [0:6] byte_in = '0;
    logic       active = 1'b0;

    logic [0:3] bits_out_a, bits_out_b;
    logic       ready_a, ready_b;
    logic [2:0] err_pos_a, err_pos_b;
    logic [7:0] err_cnt_a;
    logic [1:0] err_cnt_b;
    logic       done_a, done_b;

    int checks = 0;
    int errors = 0;

    int         m_cnt, m_err8, m_err2, pulses;
    logic       m_v1, m_done, exp_ready;
    logic [0:6] m_code;
    logic [0:3] exp_bits;
    logic [2:0] exp_pos;

    hamming74_decoder #(.MAX_WORDS(7), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .byte_in(byte_in), .active(active),
        .bits_out(bits_out_a), .ready(ready_a), .err_pos(err_pos_a),
        .err_cnt(err_cnt_a), .done(done_a));

    hamming74_decoder #(.MAX_WORDS(7), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .byte_in(byte_in), .active(active),
        .bits_out(bits_out_b), .ready(ready_b), .err_pos(err_pos_b),
        .err_cnt(err_cnt_b), .done(done_b));

    always #5 clk = ~clk;

    function automatic logic [0:6] enc(input logic [0:3] d);
        logic [0:6] c;
        c[0:3] = d;
        c[4] = d[0] ^ d[1] ^ d[3];
        c[5] = d[0] ^ d[2] ^ d[3];
        c[6] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // Perfect code: every word lies within distance 1 of one codeword
    task automatic ref_decode(input logic [0:6] w,
                              output logic [0:3] d,
                              output logic [2:0] p);
        logic [0:6] diff;
        d = '0;
        p = '0;
        for (int k = 0; k < 16; k++) begin
            diff = enc(4'(k)) ^ w;
            if ($countones(diff) <= 1) begin
                d = 4'(k);
                for (int i = 0; i < 7; i++)
                    if (diff[i]) p = 3'(i + 1);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ready_a", 32'(ready_a), 32'(exp_ready));
        chk("ready_b", 32'(ready_b), 32'(exp_ready));
        chk("bits_a", 32'(bits_out_a), 32'(exp_bits));
        chk("bits_b", 32'(bits_out_b), 32'(exp_bits));
        chk("pos_a", 32'(err_pos_a), 32'(exp_pos));
        chk("pos_b", 32'(err_pos_b), 32'(exp_pos));
        chk("cnt_a", 32'(err_cnt_a), 32'(m_err8));
        chk("cnt_b", 32'(err_cnt_b), 32'(m_err2));
        chk("done_a", 32'(done_a), 32'(m_done));
        chk("done_b", 32'(done_b), 32'(m_done));
        if (ready_a) pulses++;
    endtask

    task automatic cycle(input logic act, input logic [0:6] w);
        active  = act;
        byte_in = w;
        @(posedge clk);
        exp_ready = m_v1;
        if (m_v1) begin
            ref_decode(m_code, exp_bits, exp_pos);
            if (exp_pos != 0) begin
                m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
                m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
            end
        end
        m_v1 = act && !m_done;
        if (m_v1) begin
            m_code = w;
            m_cnt++;
            if (m_cnt == 7) m_done = 1'b1;
        end
        #1 active = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input logic act);
        reset   = 1'b1;
        active  = act;
        byte_in = 7'($urandom);
        @(posedge clk);
        m_v1 = 0; m_cnt = 0; m_done = 0; m_err8 = 0; m_err2 = 0;
        exp_bits = 0; exp_pos = 0; exp_ready = 0; m_code = 0;
        #1;
        reset  = 1'b0;
        active = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [0:6] one_err();
        logic [0:6] c;
        c = enc(4'($urandom));
        c[$urandom_range(6, 0)] ^= 1'b1;
        return c;
    endfunction

    initial begin
        do_reset(1'b0);

        // Clean, data-bit error, parity-bit error
        cycle(1'b1, 7'b1011010);
        cycle(1'b0, 7'b0);
        chk("clean_bits", 32'(bits_out_a), 32'hB);
        chk("clean_pos", 32'(err_pos_a), 32'd0);
        cycle(1'b1, 7'b0011010);
        cycle(1'b0, 7'b0);
        chk("b0_bits", 32'(bits_out_a), 32'hB);
        chk("b0_pos", 32'(err_pos_a), 32'd1);
        chk("b0_cnt", 32'(err_cnt_a), 32'd1);
        cycle(1'b1, 7'b1011011);
        cycle(1'b0, 7'b0);
        chk("p6_bits", 32'(bits_out_a), 32'hB);
        chk("p6_pos", 32'(err_pos_a), 32'd7);
        chk("p6_cnt", 32'(err_cnt_a), 32'd2);

        // Frame limit: 9 words in, 7 decoded
        do_reset(1'b0);
        pulses = 0;
        for (int i = 0; i < 9; i++) cycle(1'b1, 7'($urandom));
        for (int i = 0; i < 4; i++) cycle(1'b0, 7'b0);
        chk("frame_pulses", 32'(pulses), 32'd7);
        chk("frame_done", 32'(done_a), 32'd1);

        // Reset right after an accept drops the word
        do_reset(1'b0);
        cycle(1'b1, 7'b0011010);
        do_reset(1'b1);
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_bits", 32'(bits_out_a), 32'd0);
        cycle(1'b1, 7'b1011011);
        cycle(1'b0, 7'b0);
        chk("post_rst_pos", 32'(err_pos_a), 32'd7);

        // Saturation of the 2-bit counter
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, one_err());
        cycle(1'b0, 7'b0);
        chk("sat_b", 32'(err_cnt_b), 32'd3);
        chk("sat_a", 32'(err_cnt_a), 32'd5);

        // Randomised frames with random mid-stream resets
        for (int f = 0; f < 40; f++) begin
            do_reset(1'($urandom));
            for (int i = 0; i < 14; i++) begin
                if ($urandom_range(19, 0) == 0)
                    do_reset(1'($urandom));
                else
                    cycle(($urandom_range(3, 0) != 0), 7'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming74_decoder.md
# hamming74_decoder

Receives 7-bit Hamming(7,4) codewords from the encoding stage, computes the 3-bit syndrome, corrects any single-bit error and delivers the recovered 4-bit data word with error status. It sits directly downstream of the encoder, consuming its `byte_out` / `ready` pair. It runs a two-stage pipeline and keeps a saturating correction counter. It also closes a frame after a fixed number of words.

## Interface
- `MAX_WORDS`, default 7: words accepted per frame; after this many, input is ignored until reset.
- `CNT_W`, default 8: width of the correction counter.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `byte_in`  in  [0:6]  codeword: bits 0–3 are data d0–d3, bits 4–6 are parity p4–p6.
- `active`  in  1  `byte_in` valid this cycle; connected to encoder `ready`.
- `bits_out`  out  [0:3]  corrected data word.
- `ready`  out  1  one-cycle pulse: `bits_out` / `err_pos` valid.
- `err_pos`  out  [2:0]  0 = no error; 1..7 = codeword bit index + 1 that was flipped.
- `err_cnt`  out  [CNT_W-1:0]  number of words with nonzero syndrome, saturating.
- `done`  out  1  high once `MAX_WORDS` words are accepted; held until reset.

## Operation
- Parity definitions:
  - p4 = d0^d1^d3
  - p5 = d0^d2^d3
  - p6 = d1^d2^d3
- Syndrome bits:
  - s4 = c4^c0^c1^c3
  - s5 = c5^c0^c2^c3
  - s6 = c6^c1^c2^c3
- Syndrome {s4,s5,s6} maps to the corrected bit:
  - 110 → bit 0
  - 101 → bit 1
  - 011 → bit 2
  - 111 → bit 3
  - 100 → bit 4
  - 010 → bit 5
  - 001 → bit 6
  - 000 → no correction
- Correction and `err_pos`:
  - The mapped bit is inverted before extraction.
  - `err_pos` = mapped index + 1.
  - Parity-only errors (indices 4–6) leave the data bits unchanged but still report `err_pos` and count.
- Double-bit errors are not detected. They are miscorrected per the table; this is accepted behaviour.
- Stage 1 (accept):
  - Condition: `active`=1 and `done`=0.
  - Registers the codeword and syndrome, sets internal `v1`, and increments the word counter (width clog2(MAX_WORDS+1)).
- Stage 2 (correct):
  - When `v1`=1: registers `bits_out` and `err_pos`, pulses `ready`.
  - Increments `err_cnt` if the syndrome is nonzero and `err_cnt` is below 2^CNT_W−1.
- `done` is set in the same cycle the `MAX_WORDS`-th word is accepted. Words already in the pipeline still drain and produce `ready`.
- States:
  - IDLE/RUN: accepting words.
  - DONE: `done`=1, stage 1 ignores `active`.
  - Only `reset` leaves DONE.

## Timing
- Reset values, all outputs: `bits_out`=0, `ready`=0, `err_pos`=0, `err_cnt`=0, `done`=0. Word counter and `v1` also clear to 0.
- Latency: a word accepted at edge N appears with `ready`=1 after edge N+1. This is 2 cycles from `active` sampled to `ready` visible.
- Throughput: one word per cycle. Back-to-back `active` gives back-to-back `ready`.
- `bits_out` and `err_pos` hold their last value when `ready`=0.
- `active` sampled while `done`=1 is dropped: no `ready`, no count change.
- `reset` asserted mid-pipeline: in-flight words are discarded, and no `ready` is issued on the cycle after reset. Reset has priority over `active`.
- `err_cnt` saturates at its maximum value and does not wrap.

## Test plan
- Clean word: `byte_in`=1011010, `active` for 1 cycle → 2 cycles later `ready`=1 for 1 cycle, `bits_out`=1011, `err_pos`=0, `err_cnt`=0.
- Upstream bit-0-inverted word: `byte_in`=0011010 → `bits_out`=1011, `err_pos`=1, `err_cnt`=1.
- Parity error: `byte_in`=1011011 → `bits_out`=1011, `err_pos`=7, `err_cnt` increments.
- Frame limit, `MAX_WORDS`=7:
  - Drive 9 consecutive valid words.
  - Expect exactly 7 `ready` pulses on consecutive cycles, and `done`=1 from the 7th accept onward.
  - Words 8–9 are dropped.
- Reset mid-stream: assert `reset` on the cycle after an accept → no `ready` follows, and all outputs read 0 on the next cycle. A new word after reset decodes normally with 2-cycle latency.
- Saturation, `CNT_W`=2: feed 5 erroneous words → `err_cnt` reads 1, 2, 3, 3, 3.
